pattern_delay_sequencer: RTL and testbench
==========================================

PATTERN_DELAY_SEQUENCER -- requirements
Module: pattern_delay_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: pattern bits per channel.
REQ-002 Parameter CHANNELS, default 2: number of independent driver outputs.
REQ-003 Parameter DLY_W, default 8: width of the post-trigger delay count.
REQ-004 Parameter CNT_W, default 4: width of the repeat count.
REQ-005 i_clk  input  1  single clock; all state SHALL be in this domain.
REQ-006 i_rst  input  1  asynchronous, active-high reset.
REQ-007 i_trigger  input  1  asynchronous fire request, rising-edge sensitive.
REQ-008 i_load_valid  input  1  pattern write request.
REQ-009 o_load_ready  output  1  pattern write accepted this cycle when high with valid.
REQ-010 i_load_ch  input  max(1,$clog2(CHANNELS))  target channel of the write.
REQ-011 i_load_data  input  WIDTH  pattern; bit 0 is driven first.
REQ-012 i_delay  input  DLY_W  idle cycles between trigger detection and the first pattern bit.
REQ-013 i_repeat  input  CNT_W  extra playouts; total playouts = i_repeat+1.
REQ-014 i_mode  input  1  0 = counted playout, 1 = loop until abort.
REQ-015 i_abort  input  1  synchronous stop of an active sequence.
REQ-016 o_driver  output  CHANNELS  registered serial pattern outputs.
REQ-017 o_busy  output  1  high in DELAY and PLAY.
REQ-018 o_done  output  1  one-cycle pulse on normal completion.
REQ-019 o_overrun  output  1  sticky flag: a trigger edge was detected while not IDLE.

Function
REQ-020 i_trigger SHALL pass through a 2-flop synchronizer; an edge is detected when the synchronized value is 1 and its registered previous value is 0.
REQ-021 FSM states SHALL be IDLE, DELAY, PLAY, DONE.
REQ-022 IDLE -> DELAY on an edge when i_delay != 0; IDLE -> PLAY when i_delay == 0. i_delay, i_repeat and i_mode SHALL be latched on this transition.
REQ-023 DELAY SHALL last exactly the latched delay cycles, then go to PLAY.
REQ-024 PLAY SHALL drive o_driver[c] = pattern[c][k] for k = 0..WIDTH-1, one bit per clock, for all channels in lockstep.
REQ-025 Timing: if i_trigger is first sampled high at edge E0 and delay = D, bit k SHALL appear on o_driver after edge E0+3+D+k.
REQ-026 On wrap from k=WIDTH-1: k SHALL return to 0 with no gap cycle. The sequence SHALL continue if mode=1, or if fewer than repeat+1 playouts have completed; otherwise it SHALL go to DONE.
REQ-027 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-028 o_driver SHALL be 0 in IDLE, DELAY and DONE.
REQ-029 o_load_ready SHALL be 1 only in IDLE; an accepted load overwrites pattern[i_load_ch] on that edge. A load with i_load_ch >= CHANNELS SHALL be ignored but still handshaken.
REQ-030 A load and a trigger edge in the same IDLE cycle: the load SHALL complete on that edge, and the FSM SHALL leave IDLE on the same edge. The new pattern is in place before bit 0 is driven.
REQ-031 i_abort in DELAY or PLAY SHALL force IDLE on the next edge, with o_driver=0 and no o_done pulse. i_abort in IDLE or DONE SHALL have no effect.
REQ-032 If i_abort and a trigger edge coincide in IDLE, the trigger SHALL be accepted.
REQ-033 Trigger edges in DELAY, PLAY or DONE SHALL be ignored for sequencing and SHALL set o_overrun. o_overrun SHALL clear on an accepted load.
REQ-034 Counters SHALL never wrap silently: the playout count is CNT_W+1 bits wide and the bit index is $clog2(WIDTH) bits wide.

Reset
REQ-035 While i_rst=1: state=IDLE; o_driver=0; o_busy=0; o_done=0; o_overrun=0; o_load_ready=0; synchronizer flops=0; all pattern registers=0.
REQ-036 o_load_ready SHALL rise on the first clock after i_rst deasserts.
REQ-037 Reset asserted mid-PLAY SHALL clear o_driver immediately, without waiting for a clock edge.

Verification
REQ-038 Load ch0=0x0000_00A5, D=0, repeat=0, mode=0, trigger at E0 -> o_driver[0] = 1,0,1,0,0,1,0,1 then 0s from E0+3; o_done after 32 bits; o_busy for 32 cycles.
REQ-039 D=5, repeat=2 -> first bit at E0+8; 96 contiguous bits; exactly one o_done pulse.
REQ-040 mode=1, abort asserted at bit 40 -> pattern restarts at bit 32 without a gap; IDLE on the next edge; o_driver=0; no o_done.
REQ-041 Second trigger during PLAY -> o_overrun=1 and the sequence is unchanged; a subsequent load clears o_overrun.
REQ-042 Load and trigger in the same cycle, ch1=0xFFFF_FFFF -> o_driver[1] is all 1s for 32 cycles.
REQ-043 i_rst pulsed mid-PLAY -> all outputs 0 asynchronously; o_load_ready=1 on the first edge after release; pattern registers read back as 0.

Source files
------------

// File: rtl/pattern_delay_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pattern_delay_sequencer
// Description : Multi-channel serial pattern player. A rising edge on the
//               asynchronous i_trigger input, after synchronisation, starts a
//               sequence: an optional idle delay, then WIDTH-bit patterns
//               shifted out LSB first on every channel in lockstep. The
//               pattern repeats a counted number of times, or loops until
//               aborted.
// Ports       :
//   i_clk, i_rst        clock and asynchronous active-high reset
//   i_trigger           asynchronous fire request (rising-edge sensitive)
//   i_load_valid/ready  pattern write handshake (ready only while idle)
//   i_load_ch/data      target channel and pattern (bit 0 is driven first)
//   i_delay             idle cycles between trigger detection and bit 0
//   i_repeat            extra playouts (total playouts = i_repeat + 1)
//   i_mode              0 = counted playout, 1 = loop until abort
//   i_abort             synchronous stop of an active sequence
//   o_driver            registered serial pattern outputs, one per channel
//   o_busy / o_done     sequence active / one-cycle normal completion pulse
//   o_overrun           sticky: trigger edge seen while not idle
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_delay_sequencer #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int DLY_W    = 8,
    parameter int CNT_W    = 4
) (
    input  logic                                               i_clk,
    input  logic                                               i_rst,
    input  logic                                               i_trigger,
    input  logic                                               i_load_valid,
    output logic                                               o_load_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_load_ch,
    input  logic [WIDTH-1:0]                                   i_load_data,
    input  logic [DLY_W-1:0]                                   i_delay,
    input  logic [CNT_W-1:0]                                   i_repeat,
    input  logic                                               i_mode,
    input  logic                                               i_abort,
    output logic [CHANNELS-1:0]                                o_driver,
    output logic                                               o_busy,
    output logic                                               o_done,
    output logic                                               o_overrun
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
    localparam logic [DLY_W-1:0] c_dly_one  = DLY_W'(1);
    localparam logic [CNT_W:0]   c_play_one = (CNT_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_PLAY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync_prev;
    logic                w_trig_edge;

    logic                r_rdy_en;
    logic                w_load_acc;

    logic [DLY_W-1:0]    r_dly;
    logic [CNT_W-1:0]    r_repeat;
    logic                r_mode;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W:0]      r_plays;
    logic                w_wrap;
    logic                w_more;

    logic [CHANNELS-1:0] w_bits;
    logic [CHANNELS-1:0] r_driver;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;

    assign w_trig_edge  = r_sync2 & ~r_sync_prev;

    // r_rdy_en holds ready low through reset and the first edge after it.
    assign o_load_ready = r_rdy_en & (r_state == S_IDLE);
    assign w_load_acc   = i_load_valid & o_load_ready;

    assign w_wrap       = (r_idx == c_idx_last);
    // r_plays counts playouts completed before the current one.
    assign w_more       = r_mode | (r_plays < {1'b0, r_repeat});

    // Pattern storage; an out-of-range channel matches no entry, so such a
    // load is handshaken but discarded.
    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [WIDTH-1:0] r_pat;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_pat <= '0;
                end else if (w_load_acc && (i_load_ch == CH_W'(c))) begin
                    r_pat <= i_load_data;
                end
            end

            assign w_bits[c] = r_pat[r_idx];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trig_edge) begin
                    w_state_nxt = (i_delay != '0) ? S_DELAY : S_PLAY;
                end
            end
            S_DELAY: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_dly <= c_dly_one) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wrap && !w_more) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the state seen at each edge, so they trail
    // the FSM by one cycle: the PLAY cycle for index k emits bit k on its
    // closing edge, and the DONE cycle produces the done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
            r_rdy_en    <= 1'b0;
            r_dly       <= '0;
            r_repeat    <= '0;
            r_mode      <= 1'b0;
            r_idx       <= '0;
            r_plays     <= '0;
            r_driver    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= i_trigger;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_rdy_en    <= 1'b1;

            if ((r_state == S_IDLE) && w_trig_edge) begin
                r_dly    <= i_delay;
                r_repeat <= i_repeat;
                r_mode   <= i_mode;
                r_idx    <= '0;
                r_plays  <= '0;
            end

            if (r_state == S_DELAY) begin
                r_dly <= r_dly - c_dly_one;
            end

            if (r_state == S_PLAY) begin
                if (w_wrap) begin
                    r_idx <= '0;
                    // Saturate so an endless loop cannot roll the count over.
                    if (r_plays != '1) begin
                        r_plays <= r_plays + c_play_one;
                    end
                end else begin
                    r_idx <= r_idx + c_idx_one;
                end
            end

            r_driver <= ((r_state == S_PLAY) && !i_abort) ? w_bits : '0;
            r_busy   <= ((r_state == S_DELAY) || (r_state == S_PLAY)) && !i_abort;
            r_done   <= (r_state == S_DONE);

            if (w_load_acc) begin
                r_overrun <= 1'b0;
            end else if (w_trig_edge && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_driver  = r_driver;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pattern_delay_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_delay_sequencer
// Description : Self-checking bench for pattern_delay_sequencer. A timeline
//               model predicts every output after every clock edge; directed
//               scenarios add literal expectations on top.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pattern_delay_sequencer;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 3;
    localparam int DLY_W    = 8;
    localparam int CNT_W    = 4;
    localparam int CH_W     = 2;
    localparam int LOGN     = 8192;

    logic                clk = 1'b0;
    logic                rst;
    logic                trig;
    logic                lv;
    logic                lr;
    logic [CH_W-1:0]     lch;
    logic [WIDTH-1:0]    ldata;
    logic [DLY_W-1:0]    dly;
    logic [CNT_W-1:0]    rep;
    logic                mode;
    logic                abrt;
    logic [CHANNELS-1:0] drv;
    logic                busy;
    logic                done;
    logic                ovr;

    always #5 clk = ~clk;

    pattern_delay_sequencer #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DLY_W    (DLY_W),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_trigger    (trig),
        .i_load_valid (lv),
        .o_load_ready (lr),
        .i_load_ch    (lch),
        .i_load_data  (ldata),
        .i_delay      (dly),
        .i_repeat     (rep),
        .i_mode       (mode),
        .i_abort      (abrt),
        .o_driver     (drv),
        .o_busy       (busy),
        .o_done       (done),
        .o_overrun    (ovr)
    );

    int n_total = 0;
    int n_pass  = 0;
    int e       = 0;

    // Timeline model: a sequence accepted at edge n0 is busy on edges
    // n0+1 .. n0+D+L, emits bit j on edge n0+D+1+j, and signals done on edge
    // n0+D+L+1 (L = WIDTH*(repeat+1), unbounded in loop mode).
    bit                  m_t1, m_t2, m_t3;
    bit                  m_active;
    bit                  m_loop;
    int                  m_n0, m_D, m_L;
    bit                  m_rdy_en;
    bit                  m_ov;
    logic [WIDTH-1:0]    m_pat [CHANNELS];
    logic [CHANNELS-1:0] x_drv;
    bit                  x_busy, x_done;

    bit log_d0   [LOGN];
    bit log_d1   [LOGN];
    bit log_busy [LOGN];
    bit log_done [LOGN];
    bit log_rdy  [LOGN];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, e, act, exp);
        end
    endtask

    task automatic model_reset();
        m_t1 = 0; m_t2 = 0; m_t3 = 0;
        m_active = 0;
        m_rdy_en = 0;
        m_ov = 0;
        for (int c = 0; c < CHANNELS; c++) m_pat[c] = '0;
        x_drv = '0; x_busy = 0; x_done = 0;
    endtask

    task automatic model_edge();
        bit det, act_before, rdy_before;
        int rel, j;
        if (rst) begin
            model_reset();
            return;
        end
        det        = m_t2 && !m_t3;
        act_before = m_active;
        rdy_before = m_rdy_en && !m_active;
        m_t3 = m_t2; m_t2 = m_t1; m_t1 = trig;
        x_drv = '0; x_busy = 0; x_done = 0;
        if (act_before) begin
            rel = e - m_n0;
            if (abrt && (m_loop || rel <= m_D + m_L)) begin
                m_active = 0;
            end else if (!m_loop && rel == m_D + m_L + 1) begin
                x_done   = 1;
                m_active = 0;
            end else begin
                x_busy = 1;
                j = rel - m_D - 1;
                if (j >= 0) begin
                    for (int c = 0; c < CHANNELS; c++) x_drv[c] = m_pat[c][j % WIDTH];
                end
            end
            if (det) m_ov = 1;
        end else if (det) begin
            m_active = 1;
            m_n0     = e;
            m_D      = int'(dly);
            m_loop   = mode;
            m_L      = WIDTH * (int'(rep) + 1);
        end
        if (lv && rdy_before) begin
            m_ov = 0;
            if (int'(lch) < CHANNELS) m_pat[lch] = ldata;
        end
        m_rdy_en = 1;
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        model_edge();
        #1;
        chk("driver",  64'(drv),  64'(x_drv));
        chk("busy",    64'(busy), 64'(x_busy));
        chk("done",    64'(done), 64'(x_done));
        chk("overrun", 64'(ovr),  64'(m_ov));
        chk("ready",   64'(lr),   64'(m_rdy_en && !m_active));
        if (e < LOGN) begin
            log_d0[e]   = drv[0];
            log_d1[e]   = drv[1];
            log_busy[e] = busy;
            log_done[e] = done;
            log_rdy[e]  = lr;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] data);
        lv = 1; lch = ch; ldata = data;
        step();
        lv = 0;
    endtask

    task automatic pulse(output int e0);
        trig = 1;
        step();
        e0 = e;
        trig = 0;
    endtask

    function automatic int count_log(input int which, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            case (which)
                0:       n += int'(log_d0[i]);
                1:       n += int'(log_d1[i]);
                2:       n += int'(log_busy[i]);
                default: n += int'(log_done[i]);
            endcase
        end
        return n;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, dummy;
        logic [7:0] v;
        rst = 1; trig = 0; lv = 0; lch = '0; ldata = '0;
        dly = '0; rep = '0; mode = 0; abrt = 0;
        model_reset();
        run(3);
        rst = 0;
        step();
        chk("ready_after_reset", 64'(lr), 64'd1);

        // Single playout, no delay
        load(2'd0, 32'h0000_00A5);
        dly = 0; rep = 0; mode = 0;
        pulse(e0);
        run(40);
        for (int k = 0; k < 8; k++) v[k] = log_d0[e0 + 3 + k];
        chk("s1_bits",       64'(v), 64'hA5);
        chk("s1_not_early",  64'(log_d0[e0 + 2]), 64'd0);
        chk("s1_first_busy", 64'(log_busy[e0 + 3]), 64'd1);
        chk("s1_busy_cnt",   64'(count_log(2, e0, e0 + 40)), 64'd32);
        chk("s1_done_at",    64'(log_done[e0 + 35]), 64'd1);
        chk("s1_done_cnt",   64'(count_log(3, e0, e0 + 40)), 64'd1);

        // Delay 5, three playouts
        dly = 5; rep = 2;
        pulse(e0);
        run(110);
        chk("s2_pre_bit",    64'(log_d0[e0 + 7]), 64'd0);
        chk("s2_first_bit",  64'(log_d0[e0 + 8]), 64'd1);
        chk("s2_second_pl",  64'(log_d0[e0 + 40]), 64'd1);
        chk("s2_third_pl",   64'(log_d0[e0 + 72]), 64'd1);
        chk("s2_busy_cnt",   64'(count_log(2, e0, e0 + 110)), 64'd101);
        chk("s2_done_at",    64'(log_done[e0 + 104]), 64'd1);
        chk("s2_done_cnt",   64'(count_log(3, e0, e0 + 110)), 64'd1);

        // Loop mode, abort sampled on the edge that would emit bit 40
        dly = 0; rep = 0; mode = 1;
        pulse(e0);
        run(42);
        abrt = 1;
        step();
        abrt = 0; mode = 0;
        run(3);
        chk("s3_wrap_bit32", 64'(log_d0[e0 + 35]), 64'd1);
        chk("s3_bit34",      64'(log_d0[e0 + 37]), 64'd1);
        chk("s3_busy_pre",   64'(log_busy[e0 + 42]), 64'd1);
        chk("s3_drv_abort",  64'(log_d0[e0 + 43]), 64'd0);
        chk("s3_busy_abort", 64'(log_busy[e0 + 43]), 64'd0);
        chk("s3_rdy_abort",  64'(log_rdy[e0 + 43]), 64'd1);
        chk("s3_no_done",    64'(count_log(3, e0, e0 + 46)), 64'd0);

        // Second trigger during PLAY
        pulse(e0);
        run(10);
        pulse(dummy);
        run(30);
        chk("s4_overrun",  64'(ovr), 64'd1);
        chk("s4_done_at",  64'(log_done[e0 + 35]), 64'd1);
        chk("s4_busy_cnt", 64'(count_log(2, e0, e0 + 41)), 64'd32);
        load(2'd2, 32'h1234_5678);
        chk("s4_ov_clear", 64'(ovr), 64'd0);

        // Load and trigger detection on the same edge
        trig = 1;
        step();
        e0 = e;
        step();
        trig = 0; lv = 1; lch = 2'd1; ldata = 32'hFFFF_FFFF;
        step();
        lv = 0;
        run(38);
        chk("s5_pre",   64'(log_d1[e0 + 2]), 64'd0);
        chk("s5_ones",  64'(count_log(1, e0 + 3, e0 + 34)), 64'd32);
        chk("s5_after", 64'(log_d1[e0 + 35]), 64'd0);

        // Random traffic, including out-of-range channel loads
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) trig = ~trig;
            dly   = DLY_W'($urandom_range(0, 6));
            rep   = CNT_W'($urandom_range(0, 2));
            mode  = ($urandom_range(0, 15) == 0);
            abrt  = ($urandom_range(0, 49) == 0);
            lv    = ($urandom_range(0, 5) == 0);
            lch   = CH_W'($urandom_range(0, 3));
            ldata = $urandom;
            step();
        end
        trig = 0; lv = 0; mode = 0; abrt = 0;
        run(4);
        abrt = 1;
        step();
        abrt = 0;
        run(2);

        // Asynchronous reset in the middle of PLAY
        load(2'd0, 32'hFFFF_FFFF);
        dly = 0; rep = 0;
        pulse(e0);
        run(10);
        chk("s7_playing", 64'(drv[0]), 64'd1);
        #2 rst = 1;
        #1;
        chk("s7_async_drv",  64'(drv),  64'd0);
        chk("s7_async_busy", 64'(busy), 64'd0);
        chk("s7_async_done", 64'(done), 64'd0);
        chk("s7_async_ovr",  64'(ovr),  64'd0);
        chk("s7_async_rdy",  64'(lr),   64'd0);
        model_reset();
        run(2);
        rst = 0;
        step();
        chk("s7_ready", 64'(lr), 64'd1);
        pulse(e0);
        run(40);
        chk("s7_pat0_clear", 64'(count_log(0, e0, e0 + 40)), 64'd0);
        chk("s7_pat1_clear", 64'(count_log(1, e0, e0 + 40)), 64'd0);
        chk("s7_busy_cnt",   64'(count_log(2, e0, e0 + 40)), 64'd32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
